// File: rtl/t2mi_pkg.sv
// Shared T2-MI definitions: supervisor state encoding, packet type codes and timer sizing helper.
package t2mi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_RESYNC  = 2'd3
  } stream_state_e;

  localparam logic [7:0] PKT_BBF        = 8'h00;
  localparam logic [7:0] PKT_L1_CURRENT = 8'h10;
  localparam logic [7:0] PKT_L1_FUTURE  = 8'h11;
  localparam logic [7:0] PKT_TIMESTAMP  = 8'h20;

  localparam logic [7:0] TS_TYPE_DEFAULT = PKT_TIMESTAMP;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int tmr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t2mi_sup_timer.sv
// Loadable, clearable up-counter that strobes wrap when enabled at its terminal count and returns to 0.
module t2mi_sup_timer
  import t2mi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         wrap
);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt == term);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t2mi_stream_supervisor.sv
// T2-MI parser supervisor: parser reset sequencing, acquisition/lock tracking, forced resyncs and stream counters.
// Optional ts_rate output (timestamp packets per error window) is built when T2MI_SUPERVISOR_RATE_EN is defined.
module t2mi_stream_supervisor
  import t2mi_pkg::*;
#(
  parameter int         RST_CYCLES  = 16,
  parameter int         ACQ_TIMEOUT = 1000000,
  parameter int         PKT_TIMEOUT = 1000000,
  parameter int         ERR_WINDOW  = 4096,
  parameter int         ERR_THRESH  = 4,
  parameter logic [7:0] TS_TYPE     = TS_TYPE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        force_resync,
  input  logic        sync_locked,
  input  logic        parser_error,
  input  logic        packet_end,
  input  logic [7:0]  packet_type,
  output logic        parser_rst_n,
  output logic [1:0]  stream_state,
  output logic        stream_ok,
  output logic        ts_pkt_pulse,
  output logic [15:0] packet_count,
  output logic [15:0] error_count,
  output logic [7:0]  resync_count
`ifdef T2MI_SUPERVISOR_RATE_EN
  ,
  output logic [7:0]  ts_rate
`endif
);

  localparam int HOLD_MAX = (RST_CYCLES > ACQ_TIMEOUT) ? RST_CYCLES : ACQ_TIMEOUT;
  localparam int HW = tmr_width(HOLD_MAX);
  localparam int SW = tmr_width(PKT_TIMEOUT);
  localparam int WW = tmr_width(ERR_WINDOW);
  localparam int EW = tmr_width(ERR_THRESH + 1);

  localparam logic [HW-1:0] RST_TERM   = HW'(RST_CYCLES - 1);
  localparam logic [HW-1:0] ACQ_TERM   = HW'(ACQ_TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_TERM = SW'(PKT_TIMEOUT - 1);
  localparam logic [WW-1:0] WIN_TERM   = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LIM    = EW'(ERR_THRESH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  stream_state_e state, next_state;
  logic          restart;
  logic          hold_clr, hold_wrap;
  logic [HW-1:0] hold_term;
  logic          starve_clr, starve_wrap;
  logic          win_clr, win_wrap;
  logic          in_lock, stay_lock;
  logic [EW-1:0] err_win, err_sum;
  logic          err_trip;
  logic          pkt_hit, ts_hit;

  assign in_lock   = (state == ST_LOCKED);
  assign stay_lock = in_lock && (next_state == ST_LOCKED);
  assign pkt_hit   = in_lock && packet_end;
  assign ts_hit    = pkt_hit && (packet_type == TS_TYPE);

  // The wrap cycle starts a fresh window, seeded by an error landing on that same cycle.
  assign err_sum  = win_wrap ? EW'(parser_error) : err_win + EW'(parser_error);
  assign err_trip = (err_sum >= ERR_LIM);

  // One timer serves the IDLE/RESYNC hold and the ACQUIRE timeout; it restarts on every state change.
  assign hold_term  = (state == ST_ACQUIRE) ? ACQ_TERM : RST_TERM;
  assign hold_clr   = !enable || (next_state != state) || restart || in_lock;
  assign starve_clr = packet_end || (next_state != ST_LOCKED);
  assign win_clr    = (next_state != ST_LOCKED);

  t2mi_sup_timer #(.W(HW)) u_hold_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hold_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .term     (hold_term),
    .wrap     (hold_wrap)
  );

  t2mi_sup_timer #(.W(SW)) u_starve_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (starve_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (in_lock),
    .term     (STARVE_TERM),
    .wrap     (starve_wrap)
  );

  t2mi_sup_timer #(.W(WW)) u_win_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (in_lock),
    .term     (WIN_TERM),
    .wrap     (win_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hold_wrap) next_state = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (force_resync)     next_state = ST_RESYNC;
          else if (sync_locked) next_state = ST_LOCKED;
          else if (hold_wrap)   next_state = ST_RESYNC;
        end
        ST_LOCKED: begin
          if (force_resync || err_trip || (starve_wrap && !packet_end)) next_state = ST_RESYNC;
          else if (!sync_locked)                                         next_state = ST_ACQUIRE;
        end
        ST_RESYNC: begin
          if (force_resync)   restart    = 1'b1;
          else if (hold_wrap) next_state = ST_ACQUIRE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parser_rst_n <= 1'b0;
      stream_ok    <= 1'b0;
      ts_pkt_pulse <= 1'b0;
      packet_count <= '0;
      error_count  <= '0;
      resync_count <= '0;
      err_win      <= '0;
    end else begin
      parser_rst_n <= (next_state == ST_ACQUIRE) || (next_state == ST_LOCKED);
      stream_ok    <= (next_state == ST_LOCKED);
      ts_pkt_pulse <= ts_hit;
      if (pkt_hit)      packet_count <= packet_count + 16'd1;
      if (parser_error) error_count  <= sat_inc16(error_count);
      if ((next_state == ST_RESYNC) && (state != ST_RESYNC)) resync_count <= sat_inc8(resync_count);
      err_win <= stay_lock ? err_sum : '0;
    end
  end

  assign stream_state = state;

`ifdef T2MI_SUPERVISOR_RATE_EN
  logic [7:0] ts_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_win  <= '0;
      ts_rate <= '0;
    end else if (!stay_lock) begin
      ts_win  <= '0;
      ts_rate <= '0;
    end else if (win_wrap) begin
      ts_win  <= '0;
      ts_rate <= ts_hit ? sat_inc8(ts_win) : ts_win;
    end else if (ts_hit) begin
      ts_win  <= sat_inc8(ts_win);
    end
  end
`endif

endmodule

// File: doc/t2mi_stream_supervisor.md
Name: t2mi_stream_supervisor

Overview:
- Control-plane sequencer for the T2-MI packet parser.
- Drives the parser's reset and tracks acquisition and lock of the T2-MI stream.
- Forces a resync on error bursts, loss of lock or a packet starvation timeout; counts packets, errors and resyncs; flags timestamp packets for the PPS path.
- Sits beside the parser: takes its status and packet strobes, drives its rst_n.

Parameters:
- RST_CYCLES, 16, cycles parser_rst_n is held low per reset or resync (>=1).
- ACQ_TIMEOUT, 1000000, max cycles in ACQUIRE without sync_locked before resync.
- PKT_TIMEOUT, 1000000, max cycles in LOCKED without packet_end before resync.
- ERR_WINDOW, 4096, length in cycles of the error-burst observation window.
- ERR_THRESH, 4, parser_error pulses within one window that force a resync (>=1).
- TS_TYPE, 8'h20, packet_type value identifying timestamp packets.

Ports:
- clk, in, 1, system clock; single clock domain.
- rst_n, in, 1, synchronous active-low reset, sampled on posedge clk.
- enable, in, 1, 0 parks the block in IDLE with the parser held in reset.
- force_resync, in, 1, single-cycle software resync request.
- sync_locked, in, 1, parser sync-lock status.
- parser_error, in, 1, parser error pulse.
- packet_end, in, 1, parser end-of-packet strobe.
- packet_type, in, 8, parser packet type; stable while packet_end is high.
- parser_rst_n, out, 1, active-low reset to the parser.
- stream_state, out, 2, 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 RESYNC.
- stream_ok, out, 1, high iff state is LOCKED.
- ts_pkt_pulse, out, 1, one cycle high per timestamp packet.
- packet_count, out, 16, completed packets while LOCKED; wraps modulo 2^16.
- error_count, out, 16, parser_error pulses in any state; saturates at 16'hFFFF.
- resync_count, out, 8, entries into RESYNC; saturates at 8'hFF.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE, parser_rst_n=0, all counters 0, stream_ok=0, ts_pkt_pulse=0.
  - Reset mid-operation aborts any state immediately, with no partial update.
- All outputs are registered. A state change is visible one cycle after the triggering input is sampled.
- IDLE:
  - parser_rst_n=0; hold counter counts while enable=1.
  - After RST_CYCLES cycles with enable=1, go to ACQUIRE.
  - Hold counter clears whenever enable=0.
- ACQUIRE:
  - parser_rst_n=1; acquisition timer counts.
  - sync_locked=1 -> LOCKED.
  - Timer reaches ACQ_TIMEOUT-1 -> RESYNC.
  - sync_locked wins if both happen in the same cycle.
- LOCKED:
  - packet_end=1 -> packet_count+1.
  - packet_end=1 with packet_type==TS_TYPE -> ts_pkt_pulse=1 in the next cycle.
  - Starvation timer clears on packet_end; reaching PKT_TIMEOUT-1 -> RESYNC.
  - Error window counter runs free and wraps at ERR_WINDOW-1.
  - At the wrap cycle the window error count clears. If parser_error is also high in that cycle, the count restarts at 1.
  - Window error count reaching ERR_THRESH -> RESYNC.
  - sync_locked=0 -> ACQUIRE, with timers cleared and no resync_count increment.
- RESYNC:
  - parser_rst_n=0; resync_count+1 on entry.
  - Held for RST_CYCLES cycles, then ACQUIRE.
  - Window, starvation and acquisition timers all clear.
- Priority within any state, highest first: enable=0 (-> IDLE) > force_resync (-> RESYNC, from ACQUIRE or LOCKED) > RESYNC causes > loss of lock.
- force_resync while already in RESYNC restarts the hold count; resync_count does not increment.
- Timers are sized with $clog2 of their parameter; a timer never exceeds its parameter value.

Optional Feature:
- Macro T2MI_SUPERVISOR_RATE_EN.
- When defined:
  - Output port ts_rate, 8 bits, is added.
  - It carries the count of timestamp packets seen in the last completed ERR_WINDOW period, saturating at 8'hFF.
  - It updates at each window wrap and clears on any exit from LOCKED.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package t2mi_pkg holds the stream_state encodings, the TS_TYPE default and the L1/BBF type constants for later users.
- One sub-module, t2mi_sup_timer: loadable, clearable terminal-count timer with a wrap strobe.
- t2mi_sup_timer is instantiated three times: hold/acquisition, starvation and error window.

Test Plan (RST_CYCLES=4, ACQ_TIMEOUT=100, PKT_TIMEOUT=50, ERR_WINDOW=64, ERR_THRESH=3):
- Release rst_n with enable=1 -> parser_rst_n low for exactly 4 cycles; stream_state=1 on cycle 5.
- Assert sync_locked 10 cycles into ACQUIRE, then send packet_end pulses with types 20h, 10h, 20h -> stream_ok=1, packet_count=3, exactly two ts_pkt_pulse.
- In LOCKED, give 3 parser_error pulses within 64 cycles -> RESYNC; resync_count=1; error_count=3; parser_rst_n low 4 cycles.
- Give 2 errors, let the window wrap, then 2 more -> no resync. Then place an error on the wrap cycle followed by 2 more errors -> resync.
- Hold sync_locked=1 with no packet_end for 50 cycles -> RESYNC. Separately, never assert sync_locked -> RESYNC after 100 cycles in ACQUIRE.
- Assert force_resync and enable=0 in the same cycle -> IDLE, with no resync_count increment. Pulse rst_n low mid-RESYNC -> all counters 0, state IDLE.
